sprite_plotter: RTL and testbench

- Write-side counterpart of the sprite image loader.
- Accepts a draw request (screen location, sprite id, glyph bank id2), walks all 16x16 sprite pixels, and drives the image loader's i/j/id/id2 inputs.
- Absorbs the loader's fixed read latency and emits one plot strobe per pixel to the VGA adapter, with screen clipping and optional transparency.
- Sits between the game-control FSM (location/id generator) and the VGA adapter's x/y/colour/plot inputs.

---
 rtl/sprite_plotter_pkg.sv | 20 ++
 rtl/sprite_plotter_if.sv | 32 +++
 rtl/sprite_plotter_pixel_delay_line.sv | 26 ++
 rtl/sprite_plotter.sv | 116 +++++++++++
 tb/tb_sprite_plotter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_plotter_pkg.sv
// Shared constants, state encoding and pixel tag type for the sprite plotter.
package sprite_plotter_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int SPR_DIM  = 16;
   localparam int SPR_BITS = $clog2(SPR_DIM);
   localparam int COLOUR_W = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef struct packed {
      logic                valid;
      logic [SPR_BITS-1:0] i;
      logic [SPR_BITS-1:0] j;
   } pix_tag_t;

endpackage

// File: rtl/sprite_plotter_if.sv
// Bundle of the draw request, image-loader and VGA-side signals around the plotter.
interface sprite_plotter_if;
   import sprite_plotter_pkg::*;

   logic                start;
   logic [7:0]          locx;
   logic [7:0]          locy;
   logic [2:0]          id;
   logic [1:0]          id2;
   logic [3:0]          img_i;
   logic [5:0]          img_j;
   logic [2:0]          img_id;
   logic [1:0]          img_id2;
   logic [COLOUR_W-1:0] img_colour;
   logic [7:0]          vga_x;
   logic [6:0]          vga_y;
   logic [COLOUR_W-1:0] vga_colour;
   logic                plot;
   logic                busy;
   logic                done;

   modport slave (
      input  start, locx, locy, id, id2, img_colour,
      output img_i, img_j, img_id, img_id2, vga_x, vga_y, vga_colour, plot, busy, done
   );

   modport master (
      output start, locx, locy, id, id2, img_colour,
      input  img_i, img_j, img_id, img_id2, vga_x, vga_y, vga_colour, plot, busy, done
   );

endinterface

// File: rtl/sprite_plotter_pixel_delay_line.sv
// Shift register that carries each pixel's tag forward so it lines up with the loader's colour.
module pixel_delay_line
   import sprite_plotter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic     clock,
   input  logic     reset,
   input  pix_tag_t d,
   output pix_tag_t q
);

   pix_tag_t stage [DEPTH];

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
      end else begin
         stage[0] <= d;
         for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/sprite_plotter.sv
// Walks a 16x16 sprite through the image loader and emits clipped, optionally keyed plots.
// READ_LAT must be at least 1.
module sprite_plotter
   import sprite_plotter_pkg::*;
#(
   parameter int                  READ_LAT      = 2,
   parameter bit                  TRANSP_EN     = 1'b0,
   parameter logic [COLOUR_W-1:0] TRANSP_COLOUR = '0
) (
   input logic              clock,
   input logic              reset,
   sprite_plotter_if.slave  bus
);

   localparam int DW = $clog2(READ_LAT + 1) + 1;

   logic [1:0]          state;
   logic [7:0]          k;
   logic [DW-1:0]       drain_cnt;
   logic [7:0]          loc_x;
   logic [7:0]          loc_y;
   logic [2:0]          id_q;
   logic [1:0]          id2_q;
   pix_tag_t            tag_in;
   pix_tag_t            tag_out;
   logic [8:0]          sum_x;
   logic [8:0]          sum_y;
   logic                keep;
   logic [7:0]          x_q;
   logic [6:0]          y_q;
   logic [COLOUR_W-1:0] colour_q;
   logic                plot_q;

   // Request FSM; k is the pixel address, column in the low nibble so it varies fastest.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= ST_IDLE;
         k         <= '0;
         drain_cnt <= '0;
         loc_x     <= '0;
         loc_y     <= '0;
         id_q      <= '0;
         id2_q     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  state <= ST_FETCH;
                  k     <= '0;
                  loc_x <= bus.locx;
                  loc_y <= bus.locy;
                  id_q  <= bus.id;
                  id2_q <= bus.id2;
               end
            end
            ST_FETCH: begin
               k <= k + 8'd1;
               if (k == 8'hFF) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= '0;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == DW'(READ_LAT)) state <= ST_IDLE;
               else                            drain_cnt <= drain_cnt + 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign tag_in = '{valid: (state == ST_FETCH), i: k[3:0], j: k[7:4]};

   pixel_delay_line #(.DEPTH(READ_LAT)) u_delay (
      .clock (clock),
      .reset (reset),
      .d     (tag_in),
      .q     (tag_out)
   );

   assign sum_x = {1'b0, loc_x} + {5'b0, tag_out.i};
   assign sum_y = {1'b0, loc_y} + {5'b0, tag_out.j};
   assign keep  = tag_out.valid
                  && (sum_x < 9'(SCREEN_W))
                  && (sum_y < 9'(SCREEN_H))
                  && !(TRANSP_EN && (bus.img_colour == TRANSP_COLOUR));

   // Suppressed pixels still use their slot but leave the VGA coordinates untouched.
   always_ff @(posedge clock) begin
      if (!reset) begin
         plot_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
      end else begin
         plot_q <= keep;
         if (keep) begin
            x_q      <= sum_x[7:0];
            y_q      <= sum_y[6:0];
            colour_q <= bus.img_colour;
         end
      end
   end

   assign bus.img_i      = k[3:0];
   assign bus.img_j      = {2'b00, k[7:4]};
   assign bus.img_id     = id_q;
   assign bus.img_id2    = id2_q;
   assign bus.vga_x      = x_q;
   assign bus.vga_y      = y_q;
   assign bus.vga_colour = colour_q;
   assign bus.plot       = plot_q;
   assign bus.busy       = (state != ST_IDLE);
   assign bus.done       = (state == ST_DRAIN) && (drain_cnt == DW'(READ_LAT));

endmodule

// File: tb/tb_sprite_plotter.sv
// Scoreboard bench: two plotters (plain and colour-keyed) share stimulus; a monitor checks every cycle.
module tb_sprite_plotter;
   import sprite_plotter_pkg::*;

   localparam int LAT = 2;

   typedef struct {
      int cyc;
      int x;
      int y;
      int col;
      int id;
      int id2;
   } exp_plot_t;

   typedef struct {
      int lo;
      int hi;
      int done_cyc;
   } window_t;

   logic clock = 1'b0;
   logic reset;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   plot_count [2];

   exp_plot_t plot_q [2][$];
   window_t   win_q [$];

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   sprite_plotter_if bus_a ();
   sprite_plotter_if bus_t ();

   sprite_plotter #(.READ_LAT(LAT)) dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   sprite_plotter #(.READ_LAT(LAT), .TRANSP_EN(1'b1), .TRANSP_COLOUR(3'b000)) dut_t (
      .clock (clock),
      .reset (reset),
      .bus   (bus_t.slave)
   );

   // Loader models: colour = (i ^ j) low bits, two register stages of latency.
   logic [3:0] mix_a, mix_t;
   logic [2:0] pa1, pa2, pt1, pt2;
   assign mix_a = bus_a.img_i ^ bus_a.img_j[3:0];
   assign mix_t = bus_t.img_i ^ bus_t.img_j[3:0];
   always @(posedge clock) begin
      pa1 <= mix_a[2:0];
      pa2 <= pa1;
      pt1 <= mix_t[2:0];
      pt2 <= pt1;
   end
   assign bus_a.img_colour = pa2;
   assign bus_t.img_colour = pt2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
      end
   endtask

   task automatic set_inputs(input logic st, input int lx, input int ly, input int iid, input int iid2);
      bus_a.start = st;  bus_t.start = st;
      bus_a.locx  = 8'(lx);  bus_t.locx = 8'(lx);
      bus_a.locy  = 8'(ly);  bus_t.locy = 8'(ly);
      bus_a.id    = 3'(iid); bus_t.id   = 3'(iid);
      bus_a.id2   = 2'(iid2); bus_t.id2 = 2'(iid2);
   endtask

   task automatic expect_draw(input int base, input int lx, input int ly, input int iid, input int iid2);
      exp_plot_t e;
      window_t   w;
      for (int k = 0; k < 256; k++) begin
         int i, j, sx, sy, col;
         i   = k % 16;
         j   = k / 16;
         sx  = lx + i;
         sy  = ly + j;
         col = (i ^ j) % 8;
         if (sx < 160 && sy < 120) begin
            e = '{base + k + LAT + 1, sx % 256, sy % 128, col, iid, iid2};
            plot_q[0].push_back(e);
            if (col != 0) plot_q[1].push_back(e);
         end
      end
      w = '{base, base + 256 + LAT, base + 256 + LAT};
      win_q.push_back(w);
   endtask

   task automatic abort_at(input int c);
      exp_plot_t kept [$];
      window_t   w;
      for (int d = 0; d < 2; d++) begin
         kept = {};
         for (int n = 0; n < plot_q[d].size(); n++)
            if (plot_q[d][n].cyc <= c) kept.push_back(plot_q[d][n]);
         plot_q[d] = kept;
      end
      for (int n = 0; n < win_q.size(); n++) begin
         w = win_q[n];
         if (w.lo <= c && w.hi > c) begin
            w.hi       = c;
            w.done_cyc = -1;
            win_q[n]   = w;
         end
      end
   endtask

   task automatic check_output(input int d, input logic plot, input logic [7:0] x, input logic [6:0] y,
                               input logic [2:0] col, input logic [2:0] iid, input logic [1:0] iid2,
                               input logic busy, input logic done, input logic [3:0] ii, input logic [5:0] jj);
      logic      exp_busy;
      logic      exp_done;
      exp_plot_t e;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      for (int n = 0; n < win_q.size(); n++) begin
         if (win_q[n].lo <= cyc && cyc <= win_q[n].hi) begin
            exp_busy = 1'b1;
            if (cyc <= win_q[n].lo + 255) begin
               check($sformatf("img_i%0d", d), 32'(ii), 32'((cyc - win_q[n].lo) % 16));
               check($sformatf("img_j%0d", d), 32'(jj), 32'((cyc - win_q[n].lo) / 16));
            end
         end
         if (win_q[n].done_cyc == cyc) exp_done = 1'b1;
      end
      check($sformatf("busy%0d", d), 32'(busy), 32'(exp_busy));
      check($sformatf("done%0d", d), 32'(done), 32'(exp_done));
      if (plot === 1'b1) begin
         plot_count[d]++;
         if (plot_q[d].size() > 0 && plot_q[d][0].cyc == cyc) begin
            e = plot_q[d].pop_front();
            check($sformatf("vga_x%0d", d),      32'(x),    32'(e.x));
            check($sformatf("vga_y%0d", d),      32'(y),    32'(e.y));
            check($sformatf("vga_colour%0d", d), 32'(col),  32'(e.col));
            check($sformatf("img_id%0d", d),     32'(iid),  32'(e.id));
            check($sformatf("img_id2%0d", d),    32'(iid2), 32'(e.id2));
         end else begin
            check($sformatf("unexpected_plot%0d", d), 32'(plot), 32'(0));
         end
      end else if (plot_q[d].size() > 0 && plot_q[d][0].cyc == cyc) begin
         e = plot_q[d].pop_front();
         check($sformatf("missing_plot%0d", d), 32'(plot), 32'(1));
      end
   endtask

   always @(negedge clock) begin
      check_output(0, bus_a.plot, bus_a.vga_x, bus_a.vga_y, bus_a.vga_colour, bus_a.img_id,
                   bus_a.img_id2, bus_a.busy, bus_a.done, bus_a.img_i, bus_a.img_j);
      check_output(1, bus_t.plot, bus_t.vga_x, bus_t.vga_y, bus_t.vga_colour, bus_t.img_id,
                   bus_t.img_id2, bus_t.busy, bus_t.done, bus_t.img_i, bus_t.img_j);
   end

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clock);
   endtask

   task automatic pulse_draw(input int lx, input int ly, input int iid, input int iid2);
      set_inputs(1'b1, lx, ly, iid, iid2);
      expect_draw(cyc + 1, lx, ly, iid, iid2);
      @(negedge clock);
      set_inputs(1'b0, 255, 255, 7, 3);
   endtask

   task automatic apply_stimulus();
      int b;
      // Plain draw, clipped corner, and full draw at origin.
      pulse_draw(10, 20, 1, 2);
      wait_until(cyc + 262);
      pulse_draw(150, 115, 3, 1);
      wait_until(cyc + 262);
      pulse_draw(0, 0, 0, 0);
      wait_until(cyc + 262);

      // Start held high: mid-draw change ignored, second draw accepted after cycle 259.
      b = cyc + 1;
      set_inputs(1'b1, 40, 30, 5, 3);
      expect_draw(b, 40, 30, 5, 3);
      wait_until(b + 100);
      set_inputs(1'b1, 70, 50, 6, 1);
      wait_until(b + 259);
      expect_draw(b + 260, 70, 50, 6, 1);
      wait_until(b + 260);
      set_inputs(1'b0, 70, 50, 6, 1);
      wait_until(b + 260 + 262);

      // Reset at the edge ending cycle 100, then a clean redraw.
      b = cyc + 1;
      pulse_draw(30, 30, 2, 1);
      wait_until(b + 100);
      reset = 1'b0;
      abort_at(b + 100);
      @(negedge clock);
      reset = 1'b1;
      wait_until(cyc + 3);
      pulse_draw(20, 40, 2, 1);
      wait_until(cyc + 262);

      // Back-to-back: next request raised in cycle 259 after done.
      b = cyc + 1;
      pulse_draw(100, 60, 7, 0);
      wait_until(b + 259);
      set_inputs(1'b1, 5, 100, 4, 2);
      expect_draw(b + 260, 5, 100, 4, 2);
      @(negedge clock);
      set_inputs(1'b0, 0, 0, 0, 0);
      wait_until(b + 260 + 262);
   endtask

   initial begin
      plot_count[0] = 0;
      plot_count[1] = 0;
      reset = 1'b0;
      set_inputs(1'b0, 0, 0, 0, 0);
      repeat (3) @(negedge clock);
      check("reset_img_i",      32'(bus_a.img_i),      32'(0));
      check("reset_img_j",      32'(bus_a.img_j),      32'(0));
      check("reset_img_id",     32'(bus_a.img_id),     32'(0));
      check("reset_img_id2",    32'(bus_a.img_id2),    32'(0));
      check("reset_vga_x",      32'(bus_a.vga_x),      32'(0));
      check("reset_vga_y",      32'(bus_a.vga_y),      32'(0));
      check("reset_vga_colour", 32'(bus_a.vga_colour), 32'(0));
      check("reset_plot",       32'(bus_a.plot),       32'(0));
      check("reset_busy",       32'(bus_a.busy),       32'(0));
      check("reset_done",       32'(bus_a.done),       32'(0));
      reset = 1'b1;
      @(negedge clock);

      apply_stimulus();

      check("leftover_plots0", 32'(plot_q[0].size()), 32'(0));
      check("leftover_plots1", 32'(plot_q[1].size()), 32'(0));
      // 256+50+256+512+98+256+512 plain; keyed drops 32 per full sprite, 7 clipped, 12 aborted.
      check("plot_total0", 32'(plot_count[0]), 32'(1940));
      check("plot_total1", 32'(plot_count[1]), 32'(1697));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "[TB] time limit");
   end

endmodule
